inport: RTL and testbench
=========================

# inport

Input port for the 8-bit bus computer, the receive-side counterpart of the `out0` output register. An external producer pushes bytes through a valid/ready handshake into a small FIFO. The control unit pops them onto `data_bus` with the `c_gi` control signal. Status flags (`flag_empty`, `flag_underrun`) feed the signal controller so programs can poll or branch on input availability.

## Interface
Parameters:
- `WIDTH`, default 8: data width; matches `data_bus`.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.

Ports:
- `clk`  input  1  system clock; the same `internal_clk` domain that drives `register`/`regblock`.
- `reset`  input  1  asynchronous, active-low reset; the single clock plus async active-low reset is fixed for this block.
- `in_data`  input  WIDTH  byte from the external producer.
- `in_valid`  input  1  producer holds `in_data` valid.
- `in_ready`  output  1  port can accept a byte; equals `!flag_full`.
- `c_gi`  input  1  control: drive FIFO head onto `data_bus` and pop at the next edge.
- `c_gc`  input  1  control: clear `flag_underrun`.
- `data_bus`  inout  WIDTH  shared tri-state bus; driven only while `c_gi`=1, otherwise `'z`.
- `flag_empty`  output  1  FIFO holds 0 entries.
- `flag_full`  output  1  FIFO holds DEPTH entries.
- `flag_underrun`  output  1  sticky flag: `c_gi` was asserted while the FIFO was empty.
- `count`  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH×WIDTH register array, read pointer `rp` and write pointer `wp` of $clog2(DEPTH) bits, plus `count`. Pointers wrap modulo DEPTH.
- Push: at a rising `clk` with `in_valid && in_ready`, write `mem[wp] <= in_data`, then `wp++` and `count++`.
- Pop: at a rising `clk` with `c_gi && !flag_empty`, `rp++` and `count--`.
- Bus drive is combinational: `data_bus = c_gi ? (flag_empty ? 8'h00 : mem[rp]) : 'z`.
- Underrun: `c_gi && flag_empty` at an edge sets `flag_underrun`. No pointer changes.
- `c_gc` clears `flag_underrun`. If set and clear happen in the same cycle, set wins.
- Push while full: `in_ready`=0, so no transfer. The producer must hold `in_data` stable until accepted.
- Push and pop in the same cycle:
  - Not empty and not full: both occur, `count` is unchanged.
  - Full: only the pop occurs, because `in_ready` is low that cycle. `in_ready` rises on the next cycle.
  - Empty: the push occurs, the pop is treated as an underrun, and the bus reads 8'h00. There is no bypass.
- Reset (asynchronous, active-low, also mid-transfer): `rp`=`wp`=0, `count`=0, `flag_underrun`=0, FIFO contents discarded. Outputs during and after reset: `flag_empty`=1, `flag_full`=0, `in_ready`=1, `data_bus`='z unless `c_gi` is asserted.

## Timing
- Push to visible: a byte accepted at edge N is at the head, and drivable on the bus, in the cycle after N if the FIFO was empty.
- `c_gi` data is valid on `data_bus` combinationally within the same cycle. The bus consumer (IR/MAR/regblock/`register`) latches it at the edge where the pop occurs.
- Flags and `count` are registered-derived and update one edge after the push/pop.
- Throughput: one push and one pop per cycle.

## Structure
- Shared `symbols.vh` constants:
  - `` `IPORT_DEPTH ``.
  - Control-word bit positions for `c_gi`/`c_gc`, alongside the existing `c_go`.
  - Status indices for `flag_empty` and `flag_underrun`, consumed by `control`.
- One natural sub-module: `inport_fifo`, containing pointers, count and memory, with push/pop strobes. `inport` wraps it with the handshake, tri-state driver and underrun flag.

## Test plan
- Reset, then push 8'hA5: `in_ready`=1 and `flag_empty`=0 the next cycle. Assert `c_gi`: `data_bus`=8'hA5 that cycle, then `flag_empty`=1.
- Push 8'h01..8'h04 (DEPTH=4): `flag_full`=1 and `in_ready`=0. A fifth byte 8'h05 held valid is not accepted. Pop once, and 8'h05 is accepted the cycle after. Pops then return 01,02,03,04,05 in order, confirming wrap-around.
- `c_gi` on an empty FIFO: `data_bus`=8'h00, `flag_underrun`=1, `count` stays 0. Pulse `c_gc`, and the flag returns to 0. `c_gi`(empty) together with `c_gc` in one cycle leaves the flag set.
- Hold `count`=2 with continuous push and pop for 10 cycles: `count` stays 2 and data order is preserved.
- Assert `reset`=0 asynchronously mid-stream with 3 entries: `count`=0, `flag_empty`=1 and `in_ready`=1 immediately, without waiting for a clock edge. After release, the first pop yields the first byte pushed after reset.
- `c_gi`=0 throughout: `data_bus` stays high-Z, so other drivers such as the PC or the `regblock` output are unaffected.

Source files
------------

// File: rtl/inport_pkg.sv
// Shared constants for the input port: default geometry, control-word and status bit positions,
// and the push/pop operation encoding used by the FIFO next-state logic.
package inport_pkg;

    localparam int IPORT_DEPTH = 4;
    localparam int IPORT_WIDTH = 8;

    // Control-word bit positions; c_go belongs to the existing out0 register.
    localparam int CW_GO = 0;
    localparam int CW_GI = 1;
    localparam int CW_GC = 2;

    // Status vector indices consumed by the control unit for polling/branching.
    localparam int ST_EMPTY    = 0;
    localparam int ST_UNDERRUN = 1;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/inport_fifo.sv
// Register-array FIFO with wrapping pointers and an occupancy counter.
// Strobes are trusted: the wrapper never pushes when full or pops when empty.
module inport_fifo
    import inport_pkg::*;
#(
    parameter int WIDTH = IPORT_WIDTH,
    parameter int DEPTH = IPORT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;

    // Contents are not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        case (fifo_op(push, pop))
            FIFO_PUSH: begin
                wp_d    = wp_q + AW'(1);
                count_d = count_q + CW'(1);
            end
            FIFO_POP: begin
                rp_d    = rp_q + AW'(1);
                count_d = count_q - CW'(1);
            end
            FIFO_BOTH: begin
                wp_d = wp_q + AW'(1);
                rp_d = rp_q + AW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rp_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/inport.sv
// Receive-side bus port: valid/ready producer handshake into a small FIFO, popped onto the
// shared tri-state data bus by c_gi, with a sticky underrun flag cleared by c_gc.
module inport
    import inport_pkg::*;
#(
    parameter int WIDTH = IPORT_WIDTH,
    parameter int DEPTH = IPORT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       c_gi,
    input  logic                       c_gc,
    inout  wire  [WIDTH-1:0]           data_bus,
    output logic                       flag_empty,
    output logic                       flag_full,
    output logic                       flag_underrun,
    output logic [$clog2(DEPTH):0]     count
);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] bus_val;
    logic             underrun_q, underrun_d;

    assign in_ready = !flag_full;
    assign push     = in_valid && in_ready;
    assign pop      = c_gi && !flag_empty;

    inport_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .head    (head),
        .empty   (flag_empty),
        .full    (flag_full),
        .count   (count)
    );

    // Set has priority over clear so a same-cycle underrun is never lost.
    always_comb begin
        underrun_d = underrun_q;
        if (c_gc) begin
            underrun_d = 1'b0;
        end
        if (c_gi && flag_empty) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign flag_underrun = underrun_q;

    // No bypass: an empty FIFO reads as zero even if a byte is arriving this cycle.
    assign bus_val  = flag_empty ? '0 : head;
    assign data_bus = c_gi ? bus_val : {WIDTH{1'bz}};

endmodule

// File: tb/tb_inport.sv
// Scoreboard bench for inport: accepted bytes are queued by the stimulus, and a monitor
// compares every c_gi bus read against the queue head (zero when the model FIFO is empty).
`timescale 1ns/1ps
module tb_inport;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       c_gi;
    logic       c_gc;
    wire  [7:0] data_bus;
    logic       flag_empty;
    logic       flag_full;
    logic       flag_underrun;
    logic [2:0] count;

    int vectors;
    int miscompares;
    logic [7:0] sb [$];

    // Another bus master drives zero whenever the port should be released.
    assign data_bus = c_gi ? 8'bz : 8'h00;

    inport #(.WIDTH(8), .DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .c_gi          (c_gi),
        .c_gc          (c_gc),
        .data_bus      (data_bus),
        .flag_empty    (flag_empty),
        .flag_full     (flag_full),
        .flag_underrun (flag_underrun),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        sb.push_back(b);
        in_valid = 1'b0;
    endtask

    // Monitor: mid-cycle sampling of the bus.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (c_gi) begin
            exp_b = (sb.size() > 0) ? sb.pop_front() : 8'h00;
            check("bus_read", {24'h0, data_bus}, {24'h0, exp_b});
        end else begin
            check("bus_released", {24'h0, data_bus}, 32'h0);
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        c_gi     = 1'b0;
        c_gc     = 1'b0;

        // Reset state
        #2;
        check("rst_empty",    {31'h0, flag_empty},    32'h1);
        check("rst_full",     {31'h0, flag_full},     32'h0);
        check("rst_ready",    {31'h0, in_ready},      32'h1);
        check("rst_count",    {29'h0, count},         32'h0);
        check("rst_underrun", {31'h0, flag_underrun}, 32'h0);
        #20;
        reset = 1'b1;
        tick();

        // Single byte through
        check("a5_ready", {31'h0, in_ready}, 32'h1);
        push_byte(8'hA5);
        check("a5_not_empty", {31'h0, flag_empty}, 32'h0);
        check("a5_count",     {29'h0, count},      32'h1);
        c_gi = 1'b1;
        tick();
        c_gi = 1'b0;
        check("a5_empty_after", {31'h0, flag_empty}, 32'h1);

        // Fill, blocked fifth byte, then wrap-around drain
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        check("fill_full",  {31'h0, flag_full}, 32'h1);
        check("fill_ready", {31'h0, in_ready},  32'h0);
        check("fill_count", {29'h0, count},     32'h4);
        in_valid = 1'b1;
        in_data  = 8'h05;
        tick();
        check("blocked_count", {29'h0, count}, 32'h4);
        c_gi = 1'b1;
        tick();
        c_gi = 1'b0;
        check("pop_full_count", {29'h0, count},    32'h3);
        check("pop_full_ready", {31'h0, in_ready}, 32'h1);
        tick();
        sb.push_back(8'h05);
        in_valid = 1'b0;
        check("refill_count", {29'h0, count}, 32'h4);
        c_gi = 1'b1;
        repeat (4) tick();
        c_gi = 1'b0;
        check("drain_empty", {31'h0, flag_empty}, 32'h1);

        // Underrun set/clear/priority
        c_gi = 1'b1;
        tick();
        c_gi = 1'b0;
        check("ur_set",   {31'h0, flag_underrun}, 32'h1);
        check("ur_count", {29'h0, count},         32'h0);
        c_gc = 1'b1;
        tick();
        c_gc = 1'b0;
        check("ur_clear", {31'h0, flag_underrun}, 32'h0);
        c_gi = 1'b1;
        c_gc = 1'b1;
        tick();
        c_gi = 1'b0;
        c_gc = 1'b0;
        check("ur_set_wins", {31'h0, flag_underrun}, 32'h1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        c_gi     = 1'b1;
        tick();
        sb.push_back(8'h77);
        in_valid = 1'b0;
        c_gi     = 1'b0;
        check("empty_pushpop_count", {29'h0, count},         32'h1);
        check("empty_pushpop_ur",    {31'h0, flag_underrun}, 32'h1);
        c_gc = 1'b1;
        tick();
        c_gc = 1'b0;
        c_gi = 1'b1;
        tick();
        c_gi = 1'b0;
        check("pop77_empty", {31'h0, flag_empty},    32'h1);
        check("pop77_ur",    {31'h0, flag_underrun}, 32'h0);

        // Steady state at count=2
        push_byte(8'h20);
        push_byte(8'h21);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h22 + 8'(i);
            c_gi     = 1'b1;
            tick();
            sb.push_back(8'h22 + 8'(i));
            check("steady_count", {29'h0, count}, 32'h2);
        end
        in_valid = 1'b0;
        repeat (2) tick();
        c_gi = 1'b0;
        check("steady_drained", {31'h0, flag_empty}, 32'h1);

        // Asynchronous reset mid-stream
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        check("pre_rst_count", {29'h0, count}, 32'h3);
        #2;
        reset = 1'b0;
        #1;
        check("async_count", {29'h0, count},      32'h0);
        check("async_empty", {31'h0, flag_empty}, 32'h1);
        check("async_ready", {31'h0, in_ready},   32'h1);
        check("async_full",  {31'h0, flag_full},  32'h0);
        sb.delete();
        tick();
        tick();
        #2;
        reset = 1'b1;
        tick();
        push_byte(8'h41);
        push_byte(8'h42);
        check("post_rst_count", {29'h0, count}, 32'h2);
        c_gi = 1'b1;
        repeat (2) tick();
        c_gi = 1'b0;
        check("post_rst_empty", {31'h0, flag_empty}, 32'h1);
        check("sb_consumed", sb.size(), 32'h0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
